// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small input FIFO.
// Bytes enter over a VALID/READY handshake, are queued in a circular FIFO
// and leave on TX LSB first: one start bit, eight data bits, one stop bit,
// each held for BIT_PERIOD clocks. Back-to-back frames have no idle gap.
module uart_tx #(
   parameter int BAUD_RATE     = 9600,
   parameter int CLOCK_FREQ_HZ = 12000000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [7:0]                    DATA,
   input  logic                          VALID,
   output logic                          READY,
   output logic                          TX,
   output logic                          BUSY,
   output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

   localparam int BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int LVL_W      = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
   localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] level_s;
   logic             push_s;
   logic             pop_s;

   // Serialiser state
   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [2:0]       idx_r, idx_s;
   logic [7:0]       shift_r, shift_s;
   logic             tx_r, tx_s;
   logic             ready_r;
   logic             busy_r;

   assign push_s = VALID & ready_r;

   assign READY = ready_r;
   assign TX    = tx_r;
   assign BUSY  = busy_r;
   assign LEVEL = level_r;

   // Next-state logic: bit timing, shifting and FIFO pop requests
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      shift_s = shift_r;
      tx_s    = tx_r;
      pop_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            cnt_s = CNT_ZERO;
            idx_s = 3'd0;
            if (level_r != LVL_ZERO) begin
               pop_s   = 1'b1;
               shift_s = mem_r[rd_ptr_r];
               tx_s    = 1'b0;
               state_s = S_START;
            end else begin
               tx_s    = 1'b1;
               state_s = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s   = CNT_ZERO;
               idx_s   = 3'd0;
               tx_s    = shift_r[0];
               state_s = S_DATA;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         S_DATA: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s = CNT_ZERO;
               if (idx_r == 3'd7) begin
                  tx_s    = 1'b1;
                  state_s = S_STOP;
               end else begin
                  idx_s   = idx_r + 3'd1;
                  shift_s = {1'b0, shift_r[7:1]};
                  tx_s    = shift_r[1];
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         S_STOP: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s = CNT_ZERO;
               if (level_r != LVL_ZERO) begin
                  // Chain straight into the next frame without an idle bit
                  pop_s   = 1'b1;
                  shift_s = mem_r[rd_ptr_r];
                  tx_s    = 1'b0;
                  state_s = S_START;
               end else begin
                  tx_s    = 1'b1;
                  state_s = S_IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            cnt_s   = CNT_ZERO;
            idx_s   = 3'd0;
            tx_s    = 1'b1;
            state_s = S_IDLE;
         end
      endcase
   end

   // Occupancy after this edge; simultaneous push and pop cancel out
   always_comb begin
      level_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_s = level_r + LVL_ONE;
         2'b01:   level_s = level_r - LVL_ONE;
         default: level_s = level_r;
      endcase
   end

   // Serialiser registers; reset aborts any frame and forces the line high
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= S_IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= 3'd0;
         shift_r <= 8'h00;
         tx_r    <= 1'b1;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         shift_r <= shift_s;
         tx_r    <= tx_s;
      end
   end

   // FIFO pointers, occupancy and the registered READY/BUSY flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
         ready_r  <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         level_r <= level_s;
         ready_r <= (level_s != LVL_FULL);
         busy_r  <= (state_s != S_IDLE) || (level_s != LVL_ZERO);
      end
   end

   // FIFO storage write; contents are don't-care until a pointer covers them
   always_ff @(posedge CLK) begin
      if (push_s && !RST) begin
         mem_r[wr_ptr_r] <= DATA;
      end
   end

endmodule
